// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver.
//   ps2_state_e        frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_PFX_EXT/REL    scan-code prefixes folded by the key decoder
//   KEY_*              bit positions inside the 11-bit ps2_key word
package ps2_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned KEY_W  = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [BYTE_W-1:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [BYTE_W-1:0] PS2_PFX_REL = 8'hF0;

    localparam int unsigned KEY_TOGGLE  = 10;
    localparam int unsigned KEY_PRESSED = 9;
    localparam int unsigned KEY_EXT     = 8;

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes the PS/2 lines and deserializes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) into bytes.
// Optional inactivity timeout is compiled in with PS2_RX_TIMEOUT_EN.
//   clk_sys   in   system clock
//   reset     in   asynchronous active-high reset
//   ps2_clk   in   raw PS/2 clock (asynchronous, idle high)
//   ps2_data  in   raw PS/2 data (idle high)
//   rx_byte   out  last correctly framed byte
//   rx_strobe out  one-cycle pulse when rx_byte updates
//   rx_err    out  one-cycle pulse on framing, parity or timeout error
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_strobe,
    output logic              rx_err
);

    // The timeout comparison sits one count below TIMEOUT-1.
    if (TIMEOUT < 2) begin : g_timeout_check
        $error("ps2_frame_rx: TIMEOUT must be at least 2");
    end

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic              clk_prev;
    logic              fe_c;
    logic              data_c;
    logic              timeout_c;

    ps2_state_e        state;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] shreg;
    logic              parity_ok;

    // Two-flop synchronizers; idle-high so reset must not fake an edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fe_c   = clk_prev & ~clk_sync[1];
    assign data_c = data_sync[1];

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT);
    logic [TO_W-1:0] to_cnt;

    // Cycles since the last falling edge while a frame is open.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state == IDLE || fe_c) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Fires on the edge where the counter reaches TIMEOUT-1.
    assign timeout_c = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT - 2));
`else
    assign timeout_c = 1'b0;
`endif

    // Frame FSM with registered byte and pulse outputs.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            parity_ok <= 1'b0;
            rx_byte   <= '0;
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            rx_err    <= 1'b0;
            if (fe_c) begin
                case (state)
                    IDLE: begin
                        if (!data_c) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_c, shreg[BYTE_W-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok <= ^{shreg, data_c};
                        state     <= STOP;
                    end
                    STOP: begin
                        if (data_c && parity_ok) begin
                            rx_byte   <= shreg;
                            rx_strobe <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (timeout_c) begin
                rx_err <= 1'b1;
                state  <= IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 receiver top. Wraps the frame receiver and folds E0/F0
// prefixes into an 11-bit key-event word for the keyboard matrix logic.
// Build option: PS2_RX_TIMEOUT_EN enables the mid-frame inactivity timeout.
//   clk_sys    in   system clock
//   reset      in   asynchronous active-high reset
//   ps2_clk    in   raw PS/2 clock
//   ps2_data   in   raw PS/2 data
//   rx_byte    out  last correctly framed byte
//   rx_strobe  out  one-cycle pulse when rx_byte updates
//   rx_err     out  one-cycle pulse on any receive error
//   ps2_key    out  {toggle, pressed, extended, scan code}
//   key_strobe out  one-cycle pulse when ps2_key updates
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_strobe,
    output logic              rx_err,
    output logic [KEY_W-1:0]  ps2_key,
    output logic              key_strobe
);

    logic ext;
    logic rel;

    ps2_frame_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_frame (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .rx_err    (rx_err)
    );

    // Prefix decoder: prefixes latch flags, any other byte emits a key event.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ext        <= 1'b0;
            rel        <= 1'b0;
            ps2_key    <= '0;
            key_strobe <= 1'b0;
        end else begin
            key_strobe <= 1'b0;
            if (rx_err) begin
                ext <= 1'b0;
                rel <= 1'b0;
            end else if (rx_strobe) begin
                if (rx_byte == PS2_PFX_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == PS2_PFX_REL) begin
                    rel <= 1'b1;
                end else begin
                    ps2_key[KEY_TOGGLE]   <= ~ps2_key[KEY_TOGGLE];
                    ps2_key[KEY_PRESSED]  <= ~rel;
                    ps2_key[KEY_EXT]      <= ext;
                    ps2_key[BYTE_W-1:0]   <= rx_byte;
                    key_strobe            <= 1'b1;
                    ext                   <= 1'b0;
                    rel                   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: randomized and directed PS/2 frames checked against an
// event-level reference model (expected strobe cycles and values).
module tb_ps2_rx;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic        rx_err;
    logic [10:0] ps2_key;
    logic        key_strobe;

    ps2_rx #(.TIMEOUT(200)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_strobe  (rx_strobe),
        .rx_err     (rx_err),
        .ps2_key    (ps2_key),
        .key_strobe (key_strobe)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int overlap = 0;
    int last_fall = 0;

    int         obs_s_cyc[$];
    logic [7:0] obs_s_val[$];
    int         obs_e_cyc[$];
    int         obs_k_cyc[$];
    logic [10:0] obs_k_val[$];
    int         exp_s_cyc[$];
    logic [7:0] exp_s_val[$];
    int         exp_e_cyc[$];
    int         exp_k_cyc[$];
    logic [10:0] exp_k_val[$];

    // Reference state
    logic [7:0]  ref_byte = 8'h00;
    logic [10:0] ref_key  = 11'h000;
    bit          ref_ext  = 1'b0;
    bit          ref_rel  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Log every output pulse with the cycle it was seen in.
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (rx_strobe) begin
                obs_s_cyc.push_back(cyc);
                obs_s_val.push_back(rx_byte);
            end
            if (rx_err) obs_e_cyc.push_back(cyc);
            if (key_strobe) begin
                obs_k_cyc.push_back(cyc);
                obs_k_val.push_back(ps2_key);
            end
            if (rx_strobe && rx_err) overlap++;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            wait_cyc(hp);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(hp);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic model_good(input logic [7:0] b, input int t);
        exp_s_cyc.push_back(t + 3);
        exp_s_val.push_back(b);
        ref_byte = b;
        if (b == 8'hE0) ref_ext = 1'b1;
        else if (b == 8'hF0) ref_rel = 1'b1;
        else begin
            ref_key = {~ref_key[10], ~ref_rel, ref_ext, b};
            exp_k_cyc.push_back(t + 4);
            exp_k_val.push_back(ref_key);
            ref_ext = 1'b0;
            ref_rel = 1'b0;
        end
    endtask

    task automatic model_err(input int t);
        exp_e_cyc.push_back(t);
        ref_ext = 1'b0;
        ref_rel = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bpar, input bit bstop, input int hp);
        logic par;
        logic stp;
        par = (~^b) ^ bpar;
        stp = ~bstop;
        send_bits({stp, par, b, 1'b0}, 11, hp);
        ps2_data = 1'b1;
        if (!bpar && !bstop) model_good(b, last_fall);
        else model_err(last_fall + 3);
    endtask

    task automatic clear_queues();
        obs_s_cyc.delete(); obs_s_val.delete(); obs_e_cyc.delete();
        obs_k_cyc.delete(); obs_k_val.delete();
        exp_s_cyc.delete(); exp_s_val.delete(); exp_e_cyc.delete();
        exp_k_cyc.delete(); exp_k_val.delete();
    endtask

    // Compare logged pulses with expectations, then the output levels.
    task automatic drain(input string tag);
        int n;
        wait_cyc(8);
        check({tag, "_nstrobe"}, obs_s_cyc.size(), exp_s_cyc.size());
        check({tag, "_nerr"}, obs_e_cyc.size(), exp_e_cyc.size());
        check({tag, "_nkey"}, obs_k_cyc.size(), exp_k_cyc.size());
        n = (obs_s_cyc.size() < exp_s_cyc.size()) ? obs_s_cyc.size() : exp_s_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_strobe_cyc"}, obs_s_cyc[i], exp_s_cyc[i]);
            check({tag, "_strobe_byte"}, obs_s_val[i], exp_s_val[i]);
        end
        n = (obs_e_cyc.size() < exp_e_cyc.size()) ? obs_e_cyc.size() : exp_e_cyc.size();
        for (int i = 0; i < n; i++) check({tag, "_err_cyc"}, obs_e_cyc[i], exp_e_cyc[i]);
        n = (obs_k_cyc.size() < exp_k_cyc.size()) ? obs_k_cyc.size() : exp_k_cyc.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_key_cyc"}, obs_k_cyc[i], exp_k_cyc[i]);
            check({tag, "_key_val"}, obs_k_val[i], exp_k_val[i]);
        end
        check({tag, "_rx_byte"}, rx_byte, ref_byte);
        check({tag, "_ps2_key"}, ps2_key, ref_key);
        clear_queues();
    endtask

    task automatic do_reset();
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        reset    = 1'b1;
        wait_cyc(3);
        reset    = 1'b0;
        ref_byte = 8'h00;
        ref_key  = 11'h000;
        ref_ext  = 1'b0;
        ref_rel  = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        logic [7:0] b;
        int hp;
        wait_cyc(2);
        do_reset();
        check("reset_rx_byte", rx_byte, 8'h00);
        check("reset_ps2_key", ps2_key, 11'h000);
        check("reset_strobes", {rx_strobe, rx_err, key_strobe}, 3'b000);

        // 0x1C from reset
        send_frame(8'h1C, 0, 0, 4);
        drain("f1c");
        check("f1c_key_const", ps2_key, 11'h61C);

        // E0 F0 75 released extended key
        send_frame(8'hE0, 0, 0, 4);
        send_frame(8'hF0, 0, 0, 5);
        send_frame(8'h75, 0, 0, 3);
        drain("e0f075");
        check("e0f075_key_const", ps2_key, 11'h175);

        // bad parity, then good 0x29
        send_frame(8'h1C, 1, 0, 4);
        drain("badpar");
        send_frame(8'h29, 0, 0, 4);
        drain("f29");
        check("f29_key_const", ps2_key, 11'h629);

        // E0 then bad stop, then 0x6B must not be extended
        send_frame(8'hE0, 0, 0, 4);
        send_frame(8'h55, 0, 1, 4);
        send_frame(8'h6B, 0, 0, 4);
        drain("badstop");
        check("badstop_ext", ps2_key[8], 1'b0);

        // idle-state edge with data high is a framing error
        send_bits(11'h7FF, 1, 4);
        model_err(last_fall + 3);
        drain("idle_glitch");

        // partial frame then silence
        send_frame(8'hE0, 0, 0, 4);
        send_bits({2'b11, 8'h5A, 1'b0}, 5, 4);
`ifdef PS2_RX_TIMEOUT_EN
        model_err(last_fall + 2 + 200);
        wait_cyc(300);
        drain("timeout");
`else
        wait_cyc(300);
        drain("no_timeout");
        do_reset();
`endif
        send_frame(8'h5A, 0, 0, 4);
        drain("after_to");

        // reset in the middle of a frame
        send_bits({2'b11, 8'h33, 1'b0}, 5, 4);
        do_reset();
        drain("mid_reset");
        send_frame(8'h16, 0, 0, 4);
        drain("after_reset");
        check("after_reset_key_const", ps2_key, 11'h616);
        check("after_reset_byte_const", rx_byte, 8'h16);

        // randomized frames, including back-to-back bursts
        for (int blk = 0; blk < 8; blk++) begin
            for (int f = 0; f < 5; f++) begin
                case ($urandom_range(0, 5))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    default: b = 8'($urandom_range(0, 255));
                endcase
                hp = $urandom_range(3, 8);
                send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, hp);
                wait_cyc($urandom_range(0, 4));
            end
            drain("rand");
        end

        check("strobe_err_overlap", overlap, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
# ps2_rx

Core-side PS/2 receiver. It deserializes the framework's emulated PS/2 keyboard or mouse lines (ps2_clk/ps2_data, clock rate clk_sys/(PS2DIV*2)) into raw bytes. It also folds E0/F0 prefixes into one key-event word for the core's keyboard matrix logic. One instance is used per PS/2 channel; mouse instances ignore the key-event outputs.

## Interface
- TIMEOUT, default 50000: clk_sys cycles allowed between falling edges inside a frame. Used only when PS2_RX_TIMEOUT_EN is defined.
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high.
- ps2_clk  in  1  PS/2 clock, idle high, asynchronous to clk_sys.
- ps2_data  in  1  PS/2 data, idle high.
- rx_byte  out  8  last correctly framed byte.
- rx_strobe  out  1  one-cycle pulse when rx_byte updates.
- rx_err  out  1  one-cycle pulse on a framing, parity or timeout error.
- ps2_key  out  11  [10] toggles once per key event, [9] pressed, [8] extended, [7:0] scan code.
- key_strobe  out  1  one-cycle pulse when ps2_key updates.

## Operation
- ps2_clk and ps2_data each pass through a 2-flop synchronizer; the synchronizer flops reset to 1.
- A falling edge (fe) is registered when the previous synchronized clock is 1 and the current one is 0. Data is sampled from synchronized ps2_data in the fe cycle.
- Frame FSM:
  - IDLE: on fe with data=0, go to DATA with bit_cnt=0. On fe with data=1, pulse rx_err and stay in IDLE.
  - DATA: shift data in LSB first into shreg[7:0]. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit. Odd parity is required: XOR of the 8 data bits and the parity bit must equal 1. Go to STOP.
  - STOP: the stop bit must be 1 and parity must be good. If both hold, rx_byte<=shreg and pulse rx_strobe. Otherwise pulse rx_err and discard the byte. Return to IDLE either way.
- Prefix decoder, acting on rx_strobe:
  - E0 sets ext.
  - F0 sets rel.
  - Any other byte sets ps2_key<={~ps2_key[10], ~rel, ext, byte}, pulses key_strobe, and clears ext and rel.
  - rx_err clears ext and rel.
- No other codes are special; E1, FA and AA are emitted as plain codes.
- Reset values: rx_byte=0, ps2_key=0, all strobes=0, FSM=IDLE, ext=rel=0, bit_cnt=0.
- Reset asserted mid-frame abandons the frame. No strobe or error is produced for it.

## Timing
- Raw ps2_clk falling edge at cycle 0 gives fe at cycle 2.
- rx_strobe or rx_err is high in cycle 3 for the stop-bit edge.
- key_strobe and the new ps2_key appear in cycle 4, one cycle after rx_strobe.
- rx_strobe, rx_err and key_strobe are each exactly one cycle wide, and never more than one per frame.
- rx_strobe and rx_err are mutually exclusive.
- ps2_clk high and low phases must each last at least 3 clk_sys cycles; shorter pulses may be missed.
- Back-to-back frames with zero idle time between stop and start are accepted.

## Configuration
- PS2_RX_TIMEOUT_EN defined:
  - A counter runs while FSM≠IDLE and is cleared on every fe.
  - When it reaches TIMEOUT-1, pulse rx_err, go to IDLE, and clear ext and rel.
  - The counter width is $clog2(TIMEOUT).
- PS2_RX_TIMEOUT_EN undefined: no counter exists. A partial frame waits indefinitely and TIMEOUT is ignored.

## Structure
- ps2_pkg holds:
  - the FSM state enum (IDLE, DATA, PARITY, STOP);
  - PS2_PFX_EXT=8'hE0 and PS2_PFX_REL=8'hF0;
  - the ps2_key bit-index constants (KEY_TOGGLE=10, KEY_PRESSED=9, KEY_EXT=8).
- Sub-module ps2_frame_rx contains the synchronizer, the frame FSM and the timeout, and outputs rx_byte, rx_strobe and rx_err.
- The prefix decoder sits in the ps2_rx top.

## Test plan
- Frame 0x1C (bits 0,0,1,1,1,0,0,0, parity 0, stop 1) from reset -> rx_byte=0x1C, one rx_strobe, ps2_key=11'h61C, one key_strobe.
- Bytes E0, F0, 75 in sequence after the previous test -> three rx_strobe pulses, one key_strobe, ps2_key=11'h175.
- 0x1C sent with parity bit 1 -> rx_err pulse only; rx_byte and ps2_key unchanged. A following good 0x29 -> ps2_key=11'h629 (toggle flips from 0).
- E0 then a frame with stop bit 0 -> rx_err. Then 0x6B -> ps2_key[8]=0 (ext cleared by the error).
- With PS2_RX_TIMEOUT_EN and TIMEOUT=200: send start plus 4 data bits, then idle -> rx_err exactly 200 cycles after the last fe. A following full frame 0x5A is received correctly. Without the macro, the same stimulus gives no rx_err.
- Assert reset after the 5th bit of a frame, release it, then send 0x16 -> no strobe from the aborted frame; rx_byte=0x16; ps2_key=11'h616.
